// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf stream buffer: default width, channel slicing and handshake.
package leaf_pkg;

  localparam int unsigned DefaultPayloadBits = 32;

  // Low bit of channel k inside a flat bus of width-bit channels.
  function automatic int unsigned chan_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

  // A transfer happens on an edge where both valid and accept are high.
  function automatic logic fire(input logic vld, input logic ack);
    return vld & ack;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// One-channel first-word-fall-through FIFO with registered accept, synchronous flush and a
// saturating count of accepted words.
module leaf_stream_fifo
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = DefaultPayloadBits,
  parameter int unsigned FIFO_DEPTH_BITS = 2,
  parameter int unsigned COUNT_BITS      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [PAYLOAD_BITS-1:0] din_i,
  input  logic                    din_vld_i,
  output logic                    din_ack_o,
  output logic [PAYLOAD_BITS-1:0] dout_o,
  output logic                    dout_vld_o,
  input  logic                    dout_ack_i,
  output logic [COUNT_BITS-1:0]   count_o
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned PtrW  = FIFO_DEPTH_BITS + 1;

  logic [PAYLOAD_BITS-1:0] mem_q [Depth];
  logic [PtrW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic                    ack_q, ack_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic                    empty, full_next, fired, push, pop;

  // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
  assign empty = (wptr_q == rptr_q);
  assign fired = fire(din_vld_i, ack_q);
  assign push  = fired && !flush_i;
  assign pop   = fire(!empty, dout_ack_i) && !flush_i;

  // Next pointers, registered accept and saturating transfer count.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
    end
    full_next = (wptr_d[PtrW-1] != rptr_d[PtrW-1]) &&
                (wptr_d[FIFO_DEPTH_BITS-1:0] == rptr_d[FIFO_DEPTH_BITS-1:0]);
    ack_d = !full_next && !flush_i;
    cnt_d = cnt_q;
    // Counts producer handshakes, so it is not cleared or gated by flush.
    if (fired && (cnt_q != '1)) cnt_d = cnt_q + COUNT_BITS'(1);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ack_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty since dout is gated.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[FIFO_DEPTH_BITS-1:0]] <= din_i;
  end

  assign din_ack_o  = ack_q;
  assign dout_vld_o = !empty;
  assign dout_o     = empty ? '0 : mem_q[rptr_q[FIFO_DEPTH_BITS-1:0]];
  assign count_o    = cnt_q;

endmodule

// File: rtl/leaf_stream_buffer.sv
// Per-channel elastic buffering between the leaf interface and the user kernel, one FWFT FIFO
// per direction per channel, all on clk_user.
module leaf_stream_buffer
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = DefaultPayloadBits,
  parameter int unsigned NUM_IN_PORTS    = 4,
  parameter int unsigned NUM_OUT_PORTS   = 1,
  parameter int unsigned FIFO_DEPTH_BITS = 2,
  parameter int unsigned COUNT_BITS      = 16
) (
  input  logic                                  clk_user,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_din,
  input  logic [NUM_IN_PORTS-1:0]               in_din_vld,
  output logic [NUM_IN_PORTS-1:0]               in_din_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_dout,
  output logic [NUM_IN_PORTS-1:0]               in_dout_vld,
  input  logic [NUM_IN_PORTS-1:0]               in_dout_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_din,
  input  logic [NUM_OUT_PORTS-1:0]              out_din_vld,
  output logic [NUM_OUT_PORTS-1:0]              out_din_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_dout,
  output logic [NUM_OUT_PORTS-1:0]              out_dout_vld,
  input  logic [NUM_OUT_PORTS-1:0]              out_dout_ack,
  output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    in_count,
  output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   out_count
);

  // Interface-to-kernel channels.
  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    leaf_stream_fifo #(
      .PAYLOAD_BITS    (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS),
      .COUNT_BITS      (COUNT_BITS)
    ) u_fifo (
      .clk_i      (clk_user),
      .rst_i      (reset),
      .flush_i    (flush),
      .din_i      (in_din[chan_lo(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .din_vld_i  (in_din_vld[k]),
      .din_ack_o  (in_din_ack[k]),
      .dout_o     (in_dout[chan_lo(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .dout_vld_o (in_dout_vld[k]),
      .dout_ack_i (in_dout_ack[k]),
      .count_o    (in_count[chan_lo(k, COUNT_BITS) +: COUNT_BITS])
    );
  end

  // Kernel-to-interface channels.
  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    leaf_stream_fifo #(
      .PAYLOAD_BITS    (PAYLOAD_BITS),
      .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS),
      .COUNT_BITS      (COUNT_BITS)
    ) u_fifo (
      .clk_i      (clk_user),
      .rst_i      (reset),
      .flush_i    (flush),
      .din_i      (out_din[chan_lo(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .din_vld_i  (out_din_vld[k]),
      .din_ack_o  (out_din_ack[k]),
      .dout_o     (out_dout[chan_lo(k, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .dout_vld_o (out_dout_vld[k]),
      .dout_ack_i (out_dout_ack[k]),
      .count_o    (out_count[chan_lo(k, COUNT_BITS) +: COUNT_BITS])
    );
  end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed self-checking bench for leaf_stream_buffer: a default instance plus a narrow-counter
// instance used for the saturation case.
module tb_leaf_stream_buffer;

  logic clk_user = 1'b0;
  logic reset    = 1'b1;
  logic flush    = 1'b0;

  always #5 clk_user = ~clk_user;

  // Default instance (4 in, 1 out, 32-bit payload, 16-bit counters).
  logic [127:0] in_din;
  logic [3:0]   in_din_vld, in_din_ack, in_dout_vld, in_dout_ack;
  logic [127:0] in_dout;
  logic [31:0]  out_din, out_dout;
  logic [0:0]   out_din_vld, out_din_ack, out_dout_vld, out_dout_ack;
  logic [63:0]  in_count;
  logic [15:0]  out_count;

  // Narrow-counter instance (4-bit counters).
  logic [127:0] b_in_din;
  logic [3:0]   b_in_din_vld, b_in_din_ack, b_in_dout_vld, b_in_dout_ack;
  logic [127:0] b_in_dout;
  logic [31:0]  b_out_din, b_out_dout;
  logic [0:0]   b_out_din_vld, b_out_din_ack, b_out_dout_vld, b_out_dout_ack;
  logic [15:0]  b_in_count;
  logic [3:0]   b_out_count;

  leaf_stream_buffer dut (
    .clk_user     (clk_user),
    .reset        (reset),
    .flush        (flush),
    .in_din       (in_din),
    .in_din_vld   (in_din_vld),
    .in_din_ack   (in_din_ack),
    .in_dout      (in_dout),
    .in_dout_vld  (in_dout_vld),
    .in_dout_ack  (in_dout_ack),
    .out_din      (out_din),
    .out_din_vld  (out_din_vld),
    .out_din_ack  (out_din_ack),
    .out_dout     (out_dout),
    .out_dout_vld (out_dout_vld),
    .out_dout_ack (out_dout_ack),
    .in_count     (in_count),
    .out_count    (out_count)
  );

  leaf_stream_buffer #(
    .COUNT_BITS (4)
  ) dut_sat (
    .clk_user     (clk_user),
    .reset        (reset),
    .flush        (flush),
    .in_din       (b_in_din),
    .in_din_vld   (b_in_din_vld),
    .in_din_ack   (b_in_din_ack),
    .in_dout      (b_in_dout),
    .in_dout_vld  (b_in_dout_vld),
    .in_dout_ack  (b_in_dout_ack),
    .out_din      (b_out_din),
    .out_din_vld  (b_out_din_vld),
    .out_din_ack  (b_out_din_ack),
    .out_dout     (b_out_dout),
    .out_dout_vld (b_out_dout_vld),
    .out_dout_ack (b_out_dout_ack),
    .in_count     (b_in_count),
    .out_count    (b_out_count)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx, nrx, nacc, errs, acc_c0, rx_c0, rx_last, stalls, other_bad, cnt_at10;
    logic        a, r;
    logic [31:0] d;
    logic [31:0] got [8];

    in_din = '0; in_din_vld = '0; in_dout_ack = '0;
    out_din = '0; out_din_vld = '0; out_dout_ack = '0;
    b_in_din = '0; b_in_din_vld = '0; b_in_dout_ack = '0;
    b_out_din = '0; b_out_din_vld = '0; b_out_dout_ack = '0;

    // Reset held across an edge: every output low.
    #12;
    chk("rst_in_din_ack",   64'(in_din_ack),   64'h0);
    chk("rst_in_dout_vld",  64'(in_dout_vld),  64'h0);
    chk("rst_in_dout",      64'(in_dout[63:0]), 64'h0);
    chk("rst_out_din_ack",  64'(out_din_ack),  64'h0);
    chk("rst_out_dout_vld", 64'(out_dout_vld), 64'h0);
    chk("rst_in_count",     in_count,          64'h0);
    chk("rst_out_count",    64'(out_count),    64'h0);

    @(posedge clk_user);
    #1;
    reset = 1'b0;
    chk("ack_before_edge", 64'(in_din_ack), 64'h0);
    step();
    chk("ack_first_edge_in",  64'(in_din_ack),   64'hF);
    chk("ack_first_edge_out", 64'(out_din_ack),  64'h1);
    chk("ack_first_edge_b",   64'(b_in_din_ack), 64'hF);

    // Channel 0: six words offered, kernel stalled -> four accepted.
    idx = 0;
    in_din[31:0]  = 32'hA5A5_0001;
    in_din_vld[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a = in_din_ack[0] & in_din_vld[0];
      step();
      if (a) begin
        idx++;
        if (idx < 6) in_din[31:0] = 32'hA5A5_0001 + 32'(idx);
        else in_din_vld[0] = 1'b0;
      end
    end
    chk("full_accepted",  64'(idx),           64'd4);
    chk("full_ack_low",   64'(in_din_ack[0]), 64'h0);
    chk("full_count0",    64'(in_count[15:0]), 64'd4);
    chk("full_head_data", 64'(in_dout[31:0]), 64'hA5A5_0001);
    chk("full_head_vld",  64'(in_dout_vld[0]), 64'h1);

    // Release the kernel: all six words drain in order.
    nrx = 0;
    in_dout_ack[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      a = in_din_ack[0] & in_din_vld[0];
      r = in_dout_vld[0] & in_dout_ack[0];
      d = in_dout[31:0];
      step();
      if (a) begin
        idx++;
        if (idx < 6) in_din[31:0] = 32'hA5A5_0001 + 32'(idx);
        else in_din_vld[0] = 1'b0;
      end
      if (r && nrx < 8) begin
        got[nrx] = d;
        nrx++;
      end
    end
    in_dout_ack[0] = 1'b0;
    chk("drain_count_rx", 64'(nrx), 64'd6);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("drain_word%0d", j), 64'(got[j]), 64'(32'hA5A5_0001 + 32'(j)));
    end
    chk("drain_count0", 64'(in_count[15:0]), 64'd6);

    // Output channel 0: 20 words streaming with both sides always ready.
    nacc = 0; nrx = 0; errs = 0; acc_c0 = -1; rx_c0 = -1; rx_last = -1;
    out_dout_ack[0] = 1'b1;
    out_din         = 32'h0B00_0000;
    out_din_vld[0]  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      a = out_din_vld[0] & out_din_ack[0];
      r = out_dout_vld[0] & out_dout_ack[0];
      d = out_dout;
      step();
      if (a) begin
        if (nacc == 0) acc_c0 = c;
        nacc++;
        if (nacc < 20) out_din = 32'h0B00_0000 + 32'(nacc);
        else out_din_vld[0] = 1'b0;
      end
      if (r) begin
        if (nrx == 0) rx_c0 = c;
        if (d !== 32'h0B00_0000 + 32'(nrx)) errs++;
        rx_last = c;
        nrx++;
      end
    end
    out_dout_ack[0] = 1'b0;
    chk("stream_accepted",  64'(nacc),     64'd20);
    chk("stream_delivered", 64'(nrx),      64'd20);
    chk("stream_order",     64'(errs),     64'd0);
    chk("stream_latency",   64'(rx_c0),    64'(acc_c0 + 1));
    chk("stream_rate",      64'(rx_last),  64'(rx_c0 + 19));
    chk("stream_count",     64'(out_count), 64'd20);

    // Channel 2: three words buffered, then a one-cycle flush.
    for (int i = 0; i < 3; i++) begin
      in_din[95:64] = 32'hC0DE_0000 + 32'(i);
      in_din_vld[2] = 1'b1;
      step();
    end
    in_din_vld[2] = 1'b0;
    chk("pre_flush_vld2",   64'(in_dout_vld[2]),  64'h1);
    chk("pre_flush_count2", 64'(in_count[47:32]), 64'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_vld2",    64'(in_dout_vld[2]),  64'h0);
    chk("flush_ack_low", 64'(in_din_ack),      64'h0);
    chk("flush_count2",  64'(in_count[47:32]), 64'd3);
    chk("flush_count0",  64'(in_count[15:0]),  64'd6);
    step();
    chk("flush_ack_back", 64'(in_din_ack), 64'hF);

    // Narrow counters: 20 words on channel 1 saturate at 15; other channels untouched.
    stalls = 0; other_bad = 0; cnt_at10 = 0;
    b_in_dout_ack[1] = 1'b1;
    b_in_din_vld[1]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_in_din[63:32] = 32'(i);
      a = b_in_din_ack[1];
      step();
      if (!a) stalls++;
      if (b_in_din_ack[0] !== 1'b1 || b_in_dout_vld[0] !== 1'b0 || b_in_count[3:0] !== 4'd0)
        other_bad++;
      if (i == 9) cnt_at10 = int'(b_in_count[7:4]);
    end
    b_in_din_vld[1] = 1'b0;
    chk("sat_no_stall",  64'(stalls),            64'd0);
    chk("sat_mid_count", 64'(cnt_at10),          64'd10);
    chk("sat_count1",    64'(b_in_count[7:4]),   64'd15);
    chk("sat_other_ch",  64'(other_bad),         64'd0);
    chk("sat_count2",    64'(b_in_count[11:8]),  64'd0);
    chk("sat_out_count", 64'(b_out_count),       64'd0);

    // Reset in the middle of a cycle drops vld and ack without waiting for an edge.
    in_din[127:96] = 32'h7777_0001;
    in_din_vld[3]  = 1'b1;
    step();
    chk("mid_vld3", 64'(in_dout_vld[3]), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", 64'(in_dout_vld), 64'h0);
    chk("async_rst_ack", 64'(in_din_ack),  64'h0);
    chk("async_rst_cnt", in_count,         64'h0);
    reset = 1'b0;
    in_din_vld = '0;
    step();
    step();
    chk("post_rst_vld", 64'(in_dout_vld), 64'h0);
    chk("post_rst_ack", 64'(in_din_ack),  64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
